// File: rtl/rom_loader.sv
// rom_loader: copies flash image regions (MegaROM, Nextor, FM) into RAM one byte at a time.
// The MegaROM region exists only when ROM_LOADER_MEGAROM_EN is defined.
module rom_loader #(
`ifdef ROM_LOADER_MEGAROM_EN
    parameter logic [23:0] MEGAROM_SRC = 24'h20_0000,
    parameter logic [23:0] MEGAROM_DST = 24'h40_0000,
    parameter logic [23:0] MEGAROM_LEN = 24'h20_0000,
`endif
    parameter logic [23:0] NEXTOR_SRC = 24'h10_0000,
    parameter logic [23:0] NEXTOR_DST = 24'h7B_0000,
    parameter logic [23:0] NEXTOR_LEN = 24'h02_0000,
    parameter logic [23:0] FM_SRC     = 24'h12_0000,
    parameter logic [23:0] FM_DST     = 24'h7D_0000,
    parameter logic [23:0] FM_LEN     = 24'h00_4000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    output logic        flash_req_o,
    output logic [23:0] flash_addr_o,
    input  logic        flash_ack_i,
    input  logic [7:0]  flash_rdata_i,
    output logic        ram_wreq_o,
    output logic [23:0] ram_addr_o,
    output logic [7:0]  ram_wdata_o,
    input  logic        ram_ack_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [1:0]  region_o
);
    typedef enum logic [2:0] {IDLE, SETUP, RD, WR, FINISH} state_t;

`ifdef ROM_LOADER_MEGAROM_EN
    localparam logic [1:0] FIRST_REGION = 2'd0;
`else
    localparam logic [1:0] FIRST_REGION = 2'd1;
`endif

    state_t      state_q, state_d;
    logic [1:0]  region_q, region_d;
    logic [23:0] src_q, src_d, dst_q, dst_d, cnt_q, cnt_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        advance;
    logic [23:0] reg_src, reg_dst, reg_len;

`ifdef ROM_LOADER_MEGAROM_EN
    assign reg_src = region_q == 2'd0 ? MEGAROM_SRC : region_q == 2'd1 ? NEXTOR_SRC : FM_SRC;
    assign reg_dst = region_q == 2'd0 ? MEGAROM_DST : region_q == 2'd1 ? NEXTOR_DST : FM_DST;
    assign reg_len = region_q == 2'd0 ? MEGAROM_LEN : region_q == 2'd1 ? NEXTOR_LEN : FM_LEN;
`else
    assign reg_src = region_q == 2'd1 ? NEXTOR_SRC : FM_SRC;
    assign reg_dst = region_q == 2'd1 ? NEXTOR_DST : FM_DST;
    assign reg_len = region_q == 2'd1 ? NEXTOR_LEN : FM_LEN;
`endif

    always_comb begin
        state_d  = state_q;
        region_d = region_q;
        src_d    = src_q;
        dst_d    = dst_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        done_d   = done_q;
        advance  = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                state_d  = SETUP;
                region_d = FIRST_REGION;
                done_d   = 1'b0;
            end
            SETUP: begin
                src_d   = reg_src;
                dst_d   = reg_dst;
                cnt_d   = reg_len;
                advance = reg_len == 24'd0;
                state_d = RD;
            end
            RD: if (flash_ack_i) begin
                data_d  = flash_rdata_i;
                state_d = WR;
            end
            WR: if (ram_ack_i) begin
                src_d   = src_q + 24'd1;
                dst_d   = dst_q + 24'd1;
                cnt_d   = cnt_q - 24'd1;
                advance = cnt_q == 24'd1;
                state_d = RD;
            end
            default: state_d = IDLE;
        endcase
        // Leaving a region: next region's SETUP, or FINISH after FM.
        if (advance) begin
            state_d  = region_q == 2'd2 ? FINISH : SETUP;
            region_d = region_q == 2'd2 ? 2'd3 : region_q + 2'd1;
            done_d   = region_q == 2'd2;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            region_q <= 2'd3;
            src_q    <= 24'd0;
            dst_q    <= 24'd0;
            cnt_q    <= 24'd0;
            data_q   <= 8'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            region_q <= region_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            done_q   <= done_d;
        end
    end

    assign flash_req_o  = state_q == RD;
    assign flash_addr_o = src_q;
    assign ram_wreq_o   = state_q == WR;
    assign ram_addr_o   = dst_q;
    assign ram_wdata_o  = data_q;
    assign busy_o       = (state_q == SETUP) | (state_q == RD) | (state_q == WR);
    assign done_o       = done_q;
    assign region_o     = region_q;
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: directed bench for rom_loader with small regions and an FM region wrapping at 24'hFF_FFFF.
// Expectations follow the build: MegaROM region present only with ROM_LOADER_MEGAROM_EN.
module tb_rom_loader;
    logic        clk = 1'b0, reset_i = 1'b1, start_i = 1'b0;
    logic        flash_ack_i = 1'b0, ram_ack_i = 1'b0;
    logic [7:0]  flash_rdata_i = 8'd0;
    logic        flash_req_o, ram_wreq_o, busy_o, done_o;
    logic [23:0] flash_addr_o, ram_addr_o;
    logic [7:0]  ram_wdata_o;
    logic [1:0]  region_o;

    int tests = 0, fails = 0;
    int fdelay = 0, rdelay = 0, fwait = 0, rwait = 0;
    int overlap = 0, unstable = 0;
    logic inj_f = 1'b0, inj_r = 1'b0;
    logic [23:0] hold_fa, hold_ra;
    logic [7:0]  hold_wd;
    logic [23:0] rd_log[$], wa_log[$], exp_ra[$], exp_wa[$];
    logic [7:0]  wd_log[$], exp_wd[$];
    int nbytes, nreg;
    logic [1:0] first_region;

    always #5 clk = ~clk;

    rom_loader #(
`ifdef ROM_LOADER_MEGAROM_EN
        .MEGAROM_LEN(24'd4),
`endif
        .NEXTOR_LEN(24'd2),
        .FM_SRC(24'hFF_FFFF),
        .FM_DST(24'hFF_FFFF),
        .FM_LEN(24'd2)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i),
        .flash_req_o(flash_req_o), .flash_addr_o(flash_addr_o),
        .flash_ack_i(flash_ack_i), .flash_rdata_i(flash_rdata_i),
        .ram_wreq_o(ram_wreq_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
        .ram_ack_i(ram_ack_i), .busy_o(busy_o), .done_o(done_o), .region_o(region_o)
    );

    function automatic logic [7:0] fdata(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    // Flash/RAM responder: acks after a programmable number of wait cycles.
    always @(negedge clk) begin
        flash_ack_i = inj_f;
        ram_ack_i   = inj_r;
        if (flash_req_o && ram_wreq_o) overlap++;
        if (reset_i) begin
            fwait = 0;
            rwait = 0;
        end else begin
            if (flash_req_o) begin
                if (fwait == 0) hold_fa = flash_addr_o;
                else if (flash_addr_o !== hold_fa) unstable++;
                if (fwait == fdelay) begin
                    flash_ack_i   = 1'b1;
                    flash_rdata_i = fdata(flash_addr_o);
                    rd_log.push_back(flash_addr_o);
                    fwait = 0;
                end else fwait++;
            end
            if (ram_wreq_o) begin
                if (rwait == 0) begin
                    hold_ra = ram_addr_o;
                    hold_wd = ram_wdata_o;
                end else if (ram_addr_o !== hold_ra || ram_wdata_o !== hold_wd) unstable++;
                if (rwait == rdelay) begin
                    ram_ack_i = 1'b1;
                    wa_log.push_back(ram_addr_o);
                    wd_log.push_back(ram_wdata_o);
                    rwait = 0;
                end else rwait++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_flash_req"}, flash_req_o, 0);
        chk({p, "_ram_wreq"}, ram_wreq_o, 0);
        chk({p, "_busy"}, busy_o, 0);
        chk({p, "_done"}, done_o, 0);
        chk({p, "_region"}, region_o, 3);
        chk({p, "_flash_addr"}, flash_addr_o, 0);
        chk({p, "_ram_addr"}, ram_addr_o, 0);
        chk({p, "_ram_wdata"}, ram_wdata_o, 0);
    endtask

    task automatic add_region(input logic [23:0] s, input logic [23:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            exp_ra.push_back(s);
            exp_wa.push_back(d);
            exp_wd.push_back(fdata(s));
            s = s + 24'd1;
            d = d + 24'd1;
        end
    endtask

    task automatic clear_logs();
        rd_log.delete();
        wa_log.delete();
        wd_log.delete();
    endtask

    task automatic pulse_start(input string p);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        chk({p, "_busy_after_start"}, busy_o, 1);
        chk({p, "_done_cleared"}, done_o, 0);
        chk({p, "_first_region"}, region_o, first_region);
    endtask

    task automatic run_pass(input string p, input int per_byte, input bit mid);
        int cyc;
        logic [23:0] sa;
        clear_logs();
        pulse_start(p);
        cyc = 0;
        while (!done_o && cyc < 2000) begin
            if (mid && cyc == 7) begin
                sa = ram_addr_o;
                start_i = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
            start_i = 1'b0;
            if (mid && cyc == 8) begin
                chk({p, "_busy_start_ignored"}, busy_o, 1);
                chk({p, "_ptr_unchanged"}, ram_addr_o, sa);
            end
        end
        chk({p, "_cycles"}, cyc, per_byte * nbytes + nreg);
        chk({p, "_finish_busy"}, busy_o, 0);
        chk({p, "_finish_done"}, done_o, 1);
        chk({p, "_finish_region"}, region_o, 3);
        chk({p, "_reads"}, rd_log.size(), nbytes);
        chk({p, "_writes"}, wa_log.size(), nbytes);
        for (int i = 0; i < nbytes; i++) begin
            chk($sformatf("%s_ra%0d", p, i), i < rd_log.size() ? rd_log[i] : 24'hx, exp_ra[i]);
            chk($sformatf("%s_wa%0d", p, i), i < wa_log.size() ? wa_log[i] : 24'hx, exp_wa[i]);
            chk($sformatf("%s_wd%0d", p, i), i < wd_log.size() ? wd_log[i] : 8'hx, exp_wd[i]);
        end
        @(posedge clk); #1;
        chk({p, "_idle_done_held"}, done_o, 1);
        chk({p, "_idle_busy"}, busy_o, 0);
    endtask

    initial begin
        int n;
`ifdef ROM_LOADER_MEGAROM_EN
        add_region(24'h20_0000, 24'h40_0000, 4);
        nreg = 3;
        first_region = 2'd0;
`else
        nreg = 2;
        first_region = 2'd1;
`endif
        add_region(24'h10_0000, 24'h7B_0000, 2);
        add_region(24'hFF_FFFF, 24'hFF_FFFF, 2);
        nbytes = exp_wa.size();

        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");
        reset_i = 1'b0;

        inj_f = 1'b1;
        inj_r = 1'b1;
        @(posedge clk); #1;
        inj_f = 1'b0;
        inj_r = 1'b0;
        chk_reset("stray_ack");

        fdelay = 0; rdelay = 0;
        run_pass("p1", 2, 1'b0);

        fdelay = 3; rdelay = 5;
        run_pass("p2", 10, 1'b1);
        chk("no_overlap", overlap, 0);
        chk("held_stable", unstable, 0);

        fdelay = 0; rdelay = 5;
        clear_logs();
        pulse_start("p3");
        n = 0;
        while (!(ram_wreq_o && region_o == 2'd1) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_wr_seen", {ram_wreq_o, region_o}, 3'b101);
        reset_i = 1'b1;
        @(posedge clk); #1;
        reset_i = 1'b0;
        chk_reset("abort");
        inj_f = 1'b1;
        inj_r = 1'b1;
        @(posedge clk); #1;
        inj_f = 1'b0;
        inj_r = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("late_ack");

        fdelay = 1; rdelay = 0;
        run_pass("p4", 3, 1'b0);
        chk("no_overlap_end", overlap, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have parameter MEGAROM_SRC, default 24'h20_0000, flash start of the MegaROM image.
REQ-002 SHALL have parameter MEGAROM_DST, default 24'h40_0000, RAM start of the MegaROM image.
REQ-003 SHALL have parameter MEGAROM_LEN, default 24'h20_0000, MegaROM image length in bytes.
REQ-004 SHALL have parameter NEXTOR_SRC, default 24'h10_0000; NEXTOR_DST, default 24'h7B_0000; NEXTOR_LEN, default 24'h02_0000.
REQ-005 SHALL have parameter FM_SRC, default 24'h12_0000; FM_DST, default 24'h7D_0000; FM_LEN, default 24'h00_4000.
REQ-006 CLK  in  1  system clock; all logic on rising edge.
REQ-007 RESET  in  1  synchronous, active-high reset.
REQ-008 START  in  1  one-cycle pulse; begins a copy pass.
REQ-009 FLASH_REQ  out  1  flash read request, level, held until FLASH_ACK.
REQ-010 FLASH_ADDR  out  24  flash byte address, stable while FLASH_REQ=1.
REQ-011 FLASH_ACK  in  1  one-cycle pulse; FLASH_RDATA valid in the same cycle.
REQ-012 FLASH_RDATA  in  8  flash read byte.
REQ-013 RAM_WREQ  out  1  RAM write request, level, held until RAM_ACK.
REQ-014 RAM_ADDR  out  24  RAM byte address, stable while RAM_WREQ=1.
REQ-015 RAM_WDATA  out  8  RAM write byte, stable while RAM_WREQ=1.
REQ-016 RAM_ACK  in  1  one-cycle pulse; write accepted.
REQ-017 BUSY  out  1  copy pass in progress.
REQ-018 DONE  out  1  last pass completed; held until next START or RESET.
REQ-019 REGION  out  2  current region: 0 MegaROM, 1 Nextor, 2 FM, 3 idle.

Function
REQ-020 FSM states SHALL be IDLE, SETUP, RD, WR, FINISH.
REQ-021 IDLE: on START=1 SHALL go to SETUP with first enabled region, clear DONE, set BUSY next cycle.
REQ-022 SETUP: SHALL load source pointer, destination pointer and 24-bit remaining count from region parameters; count 0 -> advance region, else -> RD.
REQ-023 RD: FLASH_REQ=1 with FLASH_ADDR=source pointer; on FLASH_ACK latch FLASH_RDATA, drop FLASH_REQ next cycle, go to WR.
REQ-024 WR: RAM_WREQ=1, RAM_ADDR=destination pointer, RAM_WDATA=latched byte; on RAM_ACK increment both pointers, decrement count.
REQ-025 After RAM_ACK: count now 0 -> advance region; else -> RD; no idle cycle between byte transfers beyond the state change.
REQ-026 Region order SHALL be MegaROM, Nextor, FM; advance from FM SHALL go to FINISH.
REQ-027 FINISH: one cycle; BUSY=0, DONE=1, REGION=3, then IDLE.
REQ-028 FLASH_REQ and RAM_WREQ SHALL never be 1 in the same cycle; at most one outstanding request.
REQ-029 Per byte minimum latency SHALL be 2 cycles when ACK arrives in the request's first cycle.
REQ-030 START while BUSY=1 SHALL be ignored; START in IDLE with DONE=1 SHALL start a new full pass.
REQ-031 FLASH_ACK outside RD, or RAM_ACK outside WR, SHALL be ignored.
REQ-032 Pointer arithmetic SHALL be 24-bit modulo 2^24; wrap at 24'hFF_FFFF to 24'h00_0000 without error.

Reset
REQ-033 RESET=1 SHALL force IDLE; FLASH_REQ=0, RAM_WREQ=0, BUSY=0, DONE=0, REGION=3, FLASH_ADDR=0, RAM_ADDR=0, RAM_WDATA=0.
REQ-034 RESET mid-pass SHALL abort within the same edge; ACKs arriving afterwards SHALL be ignored; no resume.

Configuration
REQ-035 Macro ROM_LOADER_MEGAROM_EN defined: MegaROM region copied as REQ-026.
REQ-036 Macro undefined: MegaROM region and its parameters SHALL be removed; pass starts at Nextor; REGION never reports 0.

Verification
REQ-037 Sizes 4/2/1, ACK immediate, START -> 7 flash reads then writes in order, MegaROM bytes to DST..DST+3, DONE=1 after 14 transfer cycles plus setup.
REQ-038 FLASH_ACK delayed 3 cycles, RAM_ACK delayed 5 -> FLASH_ADDR/RAM_ADDR/RAM_WDATA held stable until ACK; data integrity byte-exact.
REQ-039 NEXTOR_LEN=0 -> Nextor skipped, REGION goes 0 -> 2, no requests with Nextor addresses.
REQ-040 RESET asserted while RAM_WREQ=1 in region 1 -> next cycle all outputs at reset values; late RAM_ACK causes no change.
REQ-041 START pulsed during BUSY -> no restart, pointers unchanged; START after DONE -> DONE=0, pass repeats from first region.
REQ-042 Build without ROM_LOADER_MEGAROM_EN -> first FLASH_ADDR=24'h10_0000, first RAM_ADDR=24'h7B_0000.
